miriscv_gpr_wb_arbiter: RTL and testbench
=========================================

Name: miriscv_gpr_wb_arbiter

Overview:
- Shares the single GPR write port between two writeback sources: the pipeline writeback (ALU/CSR/jump results) and the LSU load-response path.
- Registers the winning write for one cycle before it reaches the register file.
- Keeps a per-register pending-load scoreboard so that decode can stall on load-use hazards.
- Sits between the execute/LSU stages and the GPR file.

Parameters:
- GPR_ADDR_W, 5, GPR address width (4 when RV32E is selected).
- GPR_DEPTH, 2**GPR_ADDR_W, number of GPRs and width of the scoreboard vector.
- XLEN, 32, data width.
- STARVE_LIMIT, 3, consecutive pipeline-lost cycles before the pipeline is forced to win (legal range 1..15).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- pipe_wb_valid_i  in  1  pipeline writeback request
- pipe_wb_ready_o  out  1  pipeline request accepted this cycle
- pipe_wb_addr_i  in  GPR_ADDR_W  destination register
- pipe_wb_data_i  in  XLEN  write data
- lsu_wb_valid_i  in  1  load response request
- lsu_wb_ready_o  out  1  load response accepted this cycle
- lsu_wb_addr_i  in  GPR_ADDR_W  load destination register
- lsu_wb_data_i  in  XLEN  load data
- lsu_issue_i  in  1  load issued to memory; marks its destination pending
- lsu_issue_addr_i  in  GPR_ADDR_W  issued load destination
- gpr_wr_en_o  out  1  GPR write enable
- gpr_wr_addr_o  out  GPR_ADDR_W  GPR write address
- gpr_wr_data_o  out  XLEN  GPR write data
- gpr_busy_o  out  GPR_DEPTH  bit i set means a load to register i is outstanding

Behaviour:
- Reset (async, rst_i=1):
  - gpr_wr_en_o=0, gpr_wr_addr_o=0, gpr_wr_data_o=0.
  - gpr_busy_o all zero.
  - Starvation counter = 0.
  - Ready outputs are combinational and follow the arbitration rules below from reset onward.
- Handshake:
  - A beat transfers on a cycle where valid=1 and ready=1.
  - A requester holds valid, addr and data stable until accepted.
  - Ready outputs are combinational from the valid inputs and the counter, never from ready inputs.
- Arbitration, per cycle:
  - Only one valid: that requester gets ready=1.
  - Both valid and counter < STARVE_LIMIT: LSU wins, pipe_wb_ready_o=0, and the counter increments.
  - Both valid and counter == STARVE_LIMIT: the pipeline wins, lsu_wb_ready_o=0, and the counter clears.
  - The counter clears on any cycle the pipeline is accepted or pipe_wb_valid_i=0.
  - The counter saturates at STARVE_LIMIT.
  - Neither valid: both readies are 1 and no write occurs.
- Write latency:
  - A beat accepted at edge N appears on gpr_wr_* during cycle N+1, with gpr_wr_en_o=1 for exactly one cycle per accepted beat.
  - gpr_wr_addr_o and gpr_wr_data_o hold their last values when en=0.
- x0 handling:
  - An accepted beat with addr=0 is consumed (ready=1) but produces gpr_wr_en_o=0.
  - Address and data registers are not updated for an addr=0 beat.
- Scoreboard:
  - lsu_issue_i=1 sets busy[lsu_issue_addr_i] at the next edge; issue to x0 is ignored.
  - An accepted LSU beat clears busy[lsu_wb_addr_i] at the same edge it is registered, so the clear is visible together with gpr_wr_en_o.
  - Pipeline beats never touch the scoreboard.
  - Set and clear of the same register in one cycle: set wins, so the register stays busy.
  - Set and clear of different registers in one cycle: both take effect.
- Boundary conditions:
  - An LSU beat to a non-busy register is still written; its busy bit stays 0.
  - Back-to-back accepted beats produce back-to-back writes with no bubble.
  - Reset asserted mid-operation drops any registered write (en=0 immediately) and clears the scoreboard and counter.
  - GPR_ADDR_W=4: busy vector is 16 bits; the upper address bit does not exist.

Test Plan:
- Reset then idle → all outputs 0, both readies 1, gpr_busy_o=0.
- pipe valid, addr=5, data=0xDEADBEEF, lsu idle → pipe_ready=1; next cycle gpr_wr_en_o=1, addr=5, data=0xDEADBEEF; following cycle en=0.
- Both valid for 8 cycles, STARVE_LIMIT=3 → acceptance order LSU, LSU, LSU, PIPE, LSU, LSU, LSU, PIPE; writes appear one cycle after each acceptance with matching addr/data.
- lsu_issue to x7 → busy[7]=1; LSU beat to x7 accepted → busy[7]=0 in the same cycle gpr_wr_en_o=1, addr=7.
- lsu_issue x9 and accepted LSU beat x9 in the same cycle with busy[9]=1 → busy[9] remains 1; write to x9 occurs.
- pipe beat to x0 with data=0x1234 → ready=1, gpr_wr_en_o stays 0, gpr_wr_data_o unchanged; rst_i pulsed while a write is registered → en drops to 0 asynchronously and busy clears.

Source files
------------

// File: rtl/miriscv_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_gpr_wb_arbiter
// Purpose  : Shares the single GPR write port between the pipeline writeback
//            (ALU/CSR/jump results) and the LSU load-response path. The
//            winning write is registered for one cycle before it reaches the
//            register file. A per-register pending-load scoreboard lets decode
//            stall on load-use hazards.
// Ports    : clk_i, rst_i             - clock, asynchronous active-high reset
//            pipe_wb_valid_i/ready_o  - pipeline writeback handshake
//            pipe_wb_addr_i/data_i    - pipeline destination and data
//            lsu_wb_valid_i/ready_o   - load response handshake
//            lsu_wb_addr_i/data_i     - load destination and data
//            lsu_issue_i/addr_i       - load issued, marks destination pending
//            gpr_wr_en_o/addr_o/data_o- registered GPR write port
//            gpr_busy_o               - pending-load scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_gpr_wb_arbiter #(
  parameter int GPR_ADDR_W   = 5,
  parameter int GPR_DEPTH    = 2 ** GPR_ADDR_W,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pipe_wb_valid_i,
  output logic                  pipe_wb_ready_o,
  input  logic [GPR_ADDR_W-1:0] pipe_wb_addr_i,
  input  logic [XLEN-1:0]       pipe_wb_data_i,
  input  logic                  lsu_wb_valid_i,
  output logic                  lsu_wb_ready_o,
  input  logic [GPR_ADDR_W-1:0] lsu_wb_addr_i,
  input  logic [XLEN-1:0]       lsu_wb_data_i,
  input  logic                  lsu_issue_i,
  input  logic [GPR_ADDR_W-1:0] lsu_issue_addr_i,
  output logic                  gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0] gpr_wr_addr_o,
  output logic [XLEN-1:0]       gpr_wr_data_o,
  output logic [GPR_DEPTH-1:0]  gpr_busy_o
);

  // Four bits cover the whole legal STARVE_LIMIT range of 1..15.
  localparam int                CNT_W = 4;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      starve_cnt;
  logic                  both_valid;
  logic                  force_pipe;
  logic                  pipe_accept;
  logic                  lsu_accept;
  logic                  take_write;
  logic [GPR_ADDR_W-1:0] win_addr;
  logic [XLEN-1:0]       win_data;
  logic [GPR_DEPTH-1:0]  busy_q;
  logic [GPR_DEPTH-1:0]  busy_d;
  logic [GPR_DEPTH-1:0]  set_mask;
  logic [GPR_DEPTH-1:0]  clr_mask;

  // Arbitration only matters when both sides request; otherwise both readies
  // stay high so a lone requester is always accepted.
  assign both_valid      = pipe_wb_valid_i & lsu_wb_valid_i;
  assign force_pipe      = (starve_cnt == LIMIT);
  assign pipe_wb_ready_o = ~both_valid | force_pipe;
  assign lsu_wb_ready_o  = ~both_valid | ~force_pipe;

  assign pipe_accept = pipe_wb_valid_i & pipe_wb_ready_o;
  assign lsu_accept  = lsu_wb_valid_i & lsu_wb_ready_o;

  // At most one side is accepted per cycle, so a simple mux picks the beat.
  assign win_addr   = lsu_accept ? lsu_wb_addr_i : pipe_wb_addr_i;
  assign win_data   = lsu_accept ? lsu_wb_data_i : pipe_wb_data_i;
  // Beats to x0 are consumed but never reach the register file.
  assign take_write = (pipe_accept | lsu_accept) & (win_addr != '0);

  // Scoreboard update: clear on an accepted load response, set on issue.
  // The set is applied last so it wins when both target the same register.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (lsu_issue_i && (lsu_issue_addr_i != '0)) begin
      set_mask[lsu_issue_addr_i] = 1'b1;
    end
    if (lsu_accept) begin
      clr_mask[lsu_wb_addr_i] = 1'b1;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Starvation counter: counts consecutive cycles the pipeline requested but
  // lost; saturates at the limit, where the pipeline is then forced through.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (!pipe_wb_valid_i || pipe_accept) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port; address and data hold when no write is taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpr_wr_en_o   <= 1'b0;
      gpr_wr_addr_o <= '0;
      gpr_wr_data_o <= '0;
    end else begin
      gpr_wr_en_o <= take_write;
      if (take_write) begin
        gpr_wr_addr_o <= win_addr;
        gpr_wr_data_o <= win_data;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign gpr_busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_miriscv_gpr_wb_arbiter
// Purpose  : Self-checking bench for miriscv_gpr_wb_arbiter. Directed steps
//            followed by randomized traffic, all compared against a
//            behavioural model of the arbitration and scoreboard rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_miriscv_gpr_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv = 1'b0, lv = 1'b0, iss = 1'b0;
  logic [4:0]  paddr = '0, laddr = '0, iaddr = '0;
  logic [31:0] pdata = '0, ldata = '0;
  logic        pipe_rdy, lsu_rdy, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, busy;

  miriscv_gpr_wb_arbiter #(
    .GPR_ADDR_W  (5),
    .GPR_DEPTH   (32),
    .XLEN        (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pipe_wb_valid_i (pv),
    .pipe_wb_ready_o (pipe_rdy),
    .pipe_wb_addr_i  (paddr),
    .pipe_wb_data_i  (pdata),
    .lsu_wb_valid_i  (lv),
    .lsu_wb_ready_o  (lsu_rdy),
    .lsu_wb_addr_i   (laddr),
    .lsu_wb_data_i   (ldata),
    .lsu_issue_i     (iss),
    .lsu_issue_addr_i(iaddr),
    .gpr_wr_en_o     (wr_en),
    .gpr_wr_addr_o   (wr_addr),
    .gpr_wr_data_o   (wr_data),
    .gpr_busy_o      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          streak;          // consecutive cycles the pipeline lost
  bit          pend [32];       // registers with an outstanding load
  logic        exp_en;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        last_pa, last_la;
  byte         order_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  task automatic model_reset();
    streak   = 0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    exp_en   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  // One clock: check readies mid-cycle, then check registered outputs
  // just after the edge.
  task automatic step();
    logic epr, elr, pa, la;
    @(negedge clk);
    if (pv && lv) begin
      epr = (streak == LIMIT);
      elr = !epr;
    end else begin
      epr = 1'b1;
      elr = 1'b1;
    end
    if (pv || !lv) chk("pipe_ready", 64'(pipe_rdy), 64'(epr));
    if (lv || !pv) chk("lsu_ready", 64'(lsu_rdy), 64'(elr));
    if (lv && lsu_rdy) order_q.push_back("L");
    else if (pv && pipe_rdy) order_q.push_back("P");
    pa = pv && epr;
    la = lv && elr;
    last_pa = pa;
    last_la = la;
    @(posedge clk);
    #1;
    if (!pv || pa) streak = 0;
    else if (streak < LIMIT) streak = streak + 1;
    exp_en = 1'b0;
    if (la && laddr != 0) begin
      exp_en = 1'b1; exp_addr = laddr; exp_data = ldata;
    end else if (pa && paddr != 0) begin
      exp_en = 1'b1; exp_addr = paddr; exp_data = pdata;
    end
    if (la) pend[laddr] = 1'b0;
    if (iss && iaddr != 0) pend[iaddr] = 1'b1;
    chk("wr_en", 64'(wr_en), 64'(exp_en));
    chk("wr_addr", 64'(wr_addr), 64'(exp_addr));
    chk("wr_data", 64'(wr_data), 64'(exp_data));
    chk("busy", 64'(busy), 64'(pend_vec()));
  endtask

  initial begin
    string exp_order;
    model_reset();
    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_en", 64'(wr_en), 64'd0);
    chk("reset_addr", 64'(wr_addr), 64'd0);
    chk("reset_data", 64'(wr_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pipe_rdy", 64'(pipe_rdy), 64'd1);
    chk("reset_lsu_rdy", 64'(lsu_rdy), 64'd1);
    step();

    // Single pipeline write, then idle
    pv = 1; paddr = 5; pdata = 32'hDEADBEEF;
    step();
    pv = 0;
    step();

    // Both valid for 8 cycles
    order_q.delete();
    pv = 1; paddr = 12; pdata = 32'h1000_0000;
    lv = 1; laddr = 13; ldata = 32'h2000_0000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_la) begin laddr = 5'(14 + i); ldata = ldata + 1; end
      if (last_pa) begin paddr = 5'(20 + i); pdata = pdata + 1; end
    end
    pv = 0; lv = 0;
    exp_order = "LLLPLLLP";
    for (int i = 0; i < 8; i++)
      chk("accept_order", 64'(order_q[i]), 64'(exp_order[i]));
    step();

    // Issue to x7, then its load response
    iss = 1; iaddr = 7;
    step();
    iss = 0;
    chk("busy7_set", 64'(busy[7]), 64'd1);
    lv = 1; laddr = 7; ldata = 32'hCAFE0007;
    step();
    lv = 0;
    chk("busy7_clear", 64'(busy[7]), 64'd0);

    // x9: issue and response of the same register in one cycle
    iss = 1; iaddr = 9;
    step();
    lv = 1; laddr = 9; ldata = 32'h0000_0909;
    step();
    iss = 0; lv = 0;
    chk("busy9_kept", 64'(busy[9]), 64'd1);

    // Pipeline beat to x0
    pv = 1; paddr = 0; pdata = 32'h1234;
    step();
    pv = 0;

    // Load to a non-busy register still writes
    lv = 1; laddr = 3; ldata = 32'h3333;
    step();
    lv = 0;

    // Asynchronous reset while a write is registered and loads pending
    iss = 1; iaddr = 4;
    pv = 1; paddr = 3; pdata = 32'hABCD;
    step();
    iss = 0; pv = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_en", 64'(wr_en), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_data", 64'(wr_data), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();

    // Randomized traffic, requesters hold beats until accepted
    for (int n = 0; n < 500; n++) begin
      if (!pv || last_pa) begin
        pv = ($urandom_range(0, 2) != 0);
        paddr = 5'($urandom_range(0, 9));
        pdata = $urandom;
      end
      if (!lv || last_la) begin
        lv = ($urandom_range(0, 2) != 0);
        laddr = 5'($urandom_range(0, 9));
        ldata = $urandom;
      end
      iss = ($urandom_range(0, 2) == 0);
      iaddr = 5'($urandom_range(0, 9));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
